// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store stage. One command per cycle, in-flight reads tracked by
// a {valid, owner} tag pipeline so each response goes back to its requester.
// Fetch has a starvation guard and a flush that drops stale fetch responses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,   // 1..4
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // fetch port
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  // data port
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [DATA_W/8-1:0] i_d_be,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  // memory port
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int CNT_W = 4;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // A redirect kills any fetch-owned tag; data-owned tags pass untouched.
  function automatic tag_t flush_filter(tag_t t, logic flush);
    tag_t r;
    r = t;
    if (flush && (t.owner == OWNER_IF)) r.valid = 1'b0;
    return r;
  endfunction

  logic             if_act;
  logic             starve_hit;
  logic             if_gnt;
  logic             d_gnt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  tag_t             tag_in;
  tag_t             tag_last;
  tag_t             tag_pipe [RD_LATENCY];

  // Arbitration: data has priority unless fetch has lost STARVE_LIMIT times
  // in a row; a flush withholds the fetch grant for that cycle.
  // NOTE: combinational blocks use blocking '=' so later lines see the values
  // computed above them; clocked blocks use '<=' so all registers update
  // together from pre-edge values.
  always_comb begin
    if_act     = i_if_req & ~i_if_flush;
    starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    if_gnt     = if_act & (~i_d_req | starve_hit);
    d_gnt      = i_d_req & ~if_gnt;
  end

  // Starvation counter next value: clear when fetch wins or stops asking,
  // count (saturating) each conflict that data wins.
  // NOTE: every combinational output gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_if_req || if_gnt) begin
      starve_nxt = '0;
    end else if (i_d_req && d_gnt && !starve_hit) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // Tag for the command issued this cycle; stores produce no response.
  always_comb begin
    tag_in = '0;
    if (if_gnt) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWNER_IF;
    end else if (d_gnt && !i_d_we) begin
      tag_in.valid = 1'b1;
      tag_in.owner = OWNER_D;
    end
  end

  // Tag pipeline: shifts every cycle, matching the memory read latency.
  // NOTE: this small tag array is reset because its valid bits drive rvalid
  // directly; a large data memory would normally be left unreset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= flush_filter(tag_in, i_if_flush);
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_pipe[k] <= flush_filter(tag_pipe[k-1], i_if_flush);
      end
    end
  end

  assign tag_last = tag_pipe[RD_LATENCY-1];

  // Grant and response outputs, all held low while reset is asserted.
  always_comb begin
    o_if_gnt    = if_gnt & ~i_rst;
    o_d_gnt     = d_gnt & ~i_rst;
    o_if_rvalid = ~i_rst & ~i_if_flush & tag_last.valid &
                  (tag_last.owner == OWNER_IF);
    o_d_rvalid  = ~i_rst & tag_last.valid & (tag_last.owner == OWNER_D);
    o_if_rdata  = i_mem_rdata;
    o_d_rdata   = i_mem_rdata;
  end

  // Memory command mux: the granted requester drives the port, idle is zero.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (!i_rst) begin
      if (if_gnt) begin
        o_mem_en   = 1'b1;
        o_mem_be   = '1;
        o_mem_addr = i_if_addr;
      end else if (d_gnt) begin
        o_mem_en    = 1'b1;
        o_mem_we    = i_d_we;
        o_mem_be    = i_d_be;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 2) share one
// stimulus stream. A slot-per-cycle response schedule plus a reference memory
// predicts grants, memory commands and returned data.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_wdata;

  logic          if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a;
  logic [DW-1:0] if_rdata_a, d_rdata_a, mem_wdata_a;
  logic [BW-1:0] mem_be_a;
  logic [AW-1:0] mem_addr_a;
  logic          if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b;
  logic [DW-1:0] if_rdata_b, d_rdata_b, mem_wdata_b;
  logic [BW-1:0] mem_be_b;
  logic [AW-1:0] mem_addr_b;

  logic [DW-1:0] rd1, rd2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .STARVE_LIMIT(SL)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt_a), .o_if_rvalid(if_rvalid_a), .o_if_rdata(if_rdata_a),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt_a), .o_d_rvalid(d_rvalid_a), .o_d_rdata(d_rdata_a),
    .o_mem_en(mem_en_a), .o_mem_we(mem_we_a), .o_mem_be(mem_be_a),
    .o_mem_addr(mem_addr_a), .o_mem_wdata(mem_wdata_a), .i_mem_rdata(rd1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .STARVE_LIMIT(SL)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_gnt(if_gnt_b), .o_if_rvalid(if_rvalid_b), .o_if_rdata(if_rdata_b),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt_b), .o_d_rvalid(d_rvalid_b), .o_d_rdata(d_rdata_b),
    .o_mem_en(mem_en_b), .o_mem_we(mem_we_b), .o_mem_be(mem_be_b),
    .o_mem_addr(mem_addr_b), .o_mem_wdata(mem_wdata_b), .i_mem_rdata(rd2)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h13579BDF ^ (32'(i) * 32'h01000193);
  endfunction

  // Environment memory: driven by instance A's command port; rd1 gives one
  // cycle of latency, rd2 two cycles.
  logic [DW-1:0] env_mem [256];
  logic          env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      env_ready <= 1'b1;
    end else if (mem_en_a && mem_we_a) begin
      for (int b = 0; b < BW; b++)
        if (mem_be_a[b]) env_mem[mem_addr_a[9:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
    end
    if (mem_en_a && !mem_we_a) rd1 <= env_mem[mem_addr_a[9:2]];
    rd2 <= rd1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic        own_if;
    logic [31:0] data;
  } slot_t;

  slot_t       slot_a [8];
  slot_t       slot_b [8];
  logic [31:0] ref_mem [256];
  int          cyc;
  int          starve;

  logic          e_if_gnt, e_d_gnt, e_mem_en, e_mem_we;
  logic [BW-1:0] e_mem_be;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata;
  logic          e_if_rv_a, e_d_rv_a, e_if_rv_b, e_d_rv_b;
  logic [DW-1:0] e_data_a, e_data_b;

  task automatic model_eval();
    slot_t sa, sb;
    sa = slot_a[cyc % 8];
    sb = slot_b[cyc % 8];
    e_if_gnt = 0; e_d_gnt = 0; e_mem_en = 0; e_mem_we = 0;
    e_mem_be = '0; e_mem_addr = '0; e_mem_wdata = '0;
    e_if_rv_a = 0; e_d_rv_a = 0; e_if_rv_b = 0; e_d_rv_b = 0;
    e_data_a = sa.data; e_data_b = sb.data;
    if (!rst) begin
      if (if_req && !if_flush && (!d_req || starve == SL)) e_if_gnt = 1;
      else if (d_req) e_d_gnt = 1;
      if (e_if_gnt) begin
        e_mem_en = 1; e_mem_be = '1; e_mem_addr = if_addr;
      end else if (e_d_gnt) begin
        e_mem_en = 1; e_mem_we = d_we; e_mem_be = d_be;
        e_mem_addr = d_addr; e_mem_wdata = d_wdata;
      end
      e_if_rv_a = sa.v && sa.own_if && !if_flush;
      e_d_rv_a  = sa.v && !sa.own_if;
      e_if_rv_b = sb.v && sb.own_if && !if_flush;
      e_d_rv_b  = sb.v && !sb.own_if;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin slot_a[i].v = 0; slot_b[i].v = 0; end
      starve = 0;
    end else begin
      if (if_flush)
        for (int i = 0; i < 8; i++) begin
          if (slot_a[i].own_if) slot_a[i].v = 0;
          if (slot_b[i].own_if) slot_b[i].v = 0;
        end
      slot_a[cyc % 8].v = 0;
      slot_b[cyc % 8].v = 0;
      if (e_mem_en && !e_mem_we) begin
        slot_a[(cyc + 1) % 8] = '{1'b1, e_if_gnt, ref_mem[e_mem_addr[9:2]]};
        slot_b[(cyc + 2) % 8] = '{1'b1, e_if_gnt, ref_mem[e_mem_addr[9:2]]};
      end
      if (e_mem_en && e_mem_we)
        for (int b = 0; b < BW; b++)
          if (e_mem_be[b]) ref_mem[e_mem_addr[9:2]][8*b +: 8] = e_mem_wdata[8*b +: 8];
      if (!if_req || e_if_gnt) starve = 0;
      else if (d_req && e_d_gnt) starve = (starve < SL) ? starve + 1 : SL;
    end
    cyc++;
  endtask

  task automatic cycle_begin();
    @(negedge clk);
    model_eval();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(logic ir, logic [31:0] ia, logic fl, logic dr, logic we,
                        logic [3:0] be, logic [31:0] da, logic [31:0] wd);
    if_req = ir; if_addr = ia; if_flush = fl;
    d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    set_in(1, 32'h40, 0, 1, 1, 4'hF, 32'h80, 32'h1234);
    for (int k = 0; k < 2; k++) begin
      cycle_begin();
      n_vec++; if ({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a} !== 4'b0) begin n_err++; $display("FAIL reset_a_gnt_rv: got %b want 0000", {if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a}); end
      n_vec++; if ({mem_en_a, mem_we_a, mem_be_a} !== 6'b0) begin n_err++; $display("FAIL reset_a_mem: got %b want 000000", {mem_en_a, mem_we_a, mem_be_a}); end
      n_vec++; if ({if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b} !== 5'b0) begin n_err++; $display("FAIL reset_b: got %b want 00000", {if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b}); end
      cycle_end();
    end
    rst = 0;
    idle();
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_in(1, 32'(4 * k), 0, 0, 0, 0, 0, 0); else idle();
      cycle_begin();
      n_vec++; if (if_gnt_a !== (k < 3)) begin n_err++; $display("FAIL fetch_gnt c%0d: got %b want %b", k, if_gnt_a, k < 3); end
      n_vec++; if (mem_addr_a !== ((k < 3) ? 32'(4 * k) : 32'h0)) begin n_err++; $display("FAIL fetch_addr c%0d: got %h", k, mem_addr_a); end
      n_vec++; if (if_rvalid_a !== (k >= 1 && k <= 3)) begin n_err++; $display("FAIL fetch_rv_a c%0d: got %b want %b", k, if_rvalid_a, k >= 1 && k <= 3); end
      if (k >= 1 && k <= 3) begin
        n_vec++; if (if_rdata_a !== init_word(k - 1)) begin n_err++; $display("FAIL fetch_data_a c%0d: got %h want %h", k, if_rdata_a, init_word(k - 1)); end
      end
      n_vec++; if (if_rvalid_b !== (k >= 2)) begin n_err++; $display("FAIL fetch_rv_b c%0d: got %b want %b", k, if_rvalid_b, k >= 2); end
      if (k >= 2) begin
        n_vec++; if (if_rdata_b !== init_word(k - 2)) begin n_err++; $display("FAIL fetch_data_b c%0d: got %h want %h", k, if_rdata_b, init_word(k - 2)); end
      end
      cycle_end();
    end
    idle();
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_in(1, 32'h40, 0, 1, 0, 4'hF, 32'h100, 0);
        1: set_in(1, 32'h40, 0, 0, 0, 0, 0, 0);
        default: idle();
      endcase
      cycle_begin();
      if (k < 2) begin
        n_vec++; if ({if_gnt_a, d_gnt_a} !== ((k == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL simul_gnt c%0d: got if/d=%b", k, {if_gnt_a, d_gnt_a}); end
      end
      n_vec++; if (d_rvalid_a !== (k == 1)) begin n_err++; $display("FAIL simul_d_rv_a c%0d: got %b", k, d_rvalid_a); end
      n_vec++; if (if_rvalid_a !== (k == 2)) begin n_err++; $display("FAIL simul_if_rv_a c%0d: got %b", k, if_rvalid_a); end
      if (k == 1) begin n_vec++; if (d_rdata_a !== init_word(64)) begin n_err++; $display("FAIL simul_d_data: got %h want %h", d_rdata_a, init_word(64)); end end
      if (k == 2) begin n_vec++; if (if_rdata_a !== init_word(16)) begin n_err++; $display("FAIL simul_if_data: got %h want %h", if_rdata_a, init_word(16)); end end
      n_vec++; if ({d_rvalid_b, if_rvalid_b} !== ((k == 2) ? 2'b10 : (k == 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL simul_order_b c%0d: got d/if=%b", k, {d_rvalid_b, if_rvalid_b}); end
      cycle_end();
    end
    idle();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 6; k++) begin
      set_in(1, (k <= 4) ? 32'h80 : 32'h84, 0, 1, 0, 4'hF, 32'h200 + 32'(4 * ((k < 4) ? k : 4)), 0);
      cycle_begin();
      n_vec++; if ({if_gnt_a, d_gnt_a} !== ((k == 4) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL starve_gnt c%0d: got if/d=%b", k, {if_gnt_a, d_gnt_a}); end
      n_vec++; if (if_gnt_b !== (k == 4)) begin n_err++; $display("FAIL starve_gnt_b c%0d: got %b", k, if_gnt_b); end
      cycle_end();
    end
    idle();
    repeat (3) begin cycle_begin(); cycle_end(); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: set_in(1, 32'h8, 0, 0, 0, 0, 0, 0);
        1: set_in(1, 32'hC, 1, 1, 0, 4'hF, 32'h30, 0);
        default: idle();
      endcase
      cycle_begin();
      if (k == 0) begin n_vec++; if (if_gnt_a !== 1'b1) begin n_err++; $display("FAIL flush_pre_gnt: got %b want 1", if_gnt_a); end end
      if (k == 1) begin n_vec++; if ({if_gnt_a, d_gnt_a} !== 2'b01) begin n_err++; $display("FAIL flush_gnt: got if/d=%b want 01", {if_gnt_a, d_gnt_a}); end end
      n_vec++; if ({if_rvalid_a, if_rvalid_b} !== 2'b00) begin n_err++; $display("FAIL flush_if_rv c%0d: got a/b=%b want 00", k, {if_rvalid_a, if_rvalid_b}); end
      n_vec++; if ({d_rvalid_a, d_rvalid_b} !== ((k == 2) ? 2'b10 : (k == 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL flush_d_rv c%0d: got a/b=%b", k, {d_rvalid_a, d_rvalid_b}); end
      if (k == 2) begin n_vec++; if (d_rdata_a !== init_word(12)) begin n_err++; $display("FAIL flush_d_data_a: got %h want %h", d_rdata_a, init_word(12)); end end
      if (k == 3) begin n_vec++; if (d_rdata_b !== init_word(12)) begin n_err++; $display("FAIL flush_d_data_b: got %h want %h", d_rdata_b, init_word(12)); end end
      cycle_end();
    end
  endtask

  task automatic test_store();
    logic [31:0] w;
    w = init_word(8);
    w = {w[31:16], 16'hBEEF};
    for (int k = 0; k < 7; k++) begin
      if (k == 0) set_in(0, 0, 0, 1, 1, 4'b0011, 32'h20, 32'hDEADBEEF);
      else if (k == 4) set_in(0, 0, 0, 1, 0, 4'hF, 32'h20, 0);
      else idle();
      cycle_begin();
      n_vec++; if (mem_we_a !== (k == 0)) begin n_err++; $display("FAIL store_we c%0d: got %b", k, mem_we_a); end
      n_vec++; if (mem_be_a !== ((k == 0) ? 4'b0011 : (k == 4) ? 4'hF : 4'h0)) begin n_err++; $display("FAIL store_be c%0d: got %b", k, mem_be_a); end
      if (k == 0) begin
        n_vec++; if ({d_gnt_a, mem_en_a, mem_addr_a, mem_wdata_a} !== {2'b11, 32'h20, 32'hDEADBEEF}) begin n_err++; $display("FAIL store_cmd: got gnt=%b en=%b addr=%h wd=%h", d_gnt_a, mem_en_a, mem_addr_a, mem_wdata_a); end
      end
      n_vec++; if ({d_rvalid_a, d_rvalid_b} !== ((k == 5) ? 2'b10 : (k == 6) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL store_rv c%0d: got a/b=%b", k, {d_rvalid_a, d_rvalid_b}); end
      if (k == 5) begin n_vec++; if (d_rdata_a !== w) begin n_err++; $display("FAIL store_merge_a: got %h want %h", d_rdata_a, w); end end
      if (k == 6) begin n_vec++; if (d_rdata_b !== w) begin n_err++; $display("FAIL store_merge_b: got %h want %h", d_rdata_b, w); end end
      cycle_end();
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    set_in(1, 32'h10, 0, 0, 0, 0, 0, 0);
    cycle_begin(); cycle_end();
    set_in(0, 0, 0, 1, 0, 4'hF, 32'h14, 0);
    cycle_begin(); cycle_end();
    rst = 1;
    set_in(1, 32'h18, 0, 1, 0, 4'hF, 32'h1C, 0);
    cycle_begin();
    n_vec++; if ({if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a, mem_we_a, mem_be_a} !== 10'b0) begin n_err++; $display("FAIL rst_inflight_a: got %b want 0", {if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a, mem_we_a, mem_be_a}); end
    n_vec++; if ({if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b} !== 5'b0) begin n_err++; $display("FAIL rst_inflight_b: got %b want 0", {if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b}); end
    cycle_end();
    rst = 0;
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      n_vec++; if ({if_rvalid_a, d_rvalid_a, if_rvalid_b, d_rvalid_b} !== 4'b0) begin n_err++; $display("FAIL rst_release_rv c%0d: got %b want 0000", k, {if_rvalid_a, d_rvalid_a, if_rvalid_b, d_rvalid_b}); end
      cycle_end();
    end
  endtask

  task automatic test_random();
    logic if_pend, d_pend;
    if_pend = 0; d_pend = 0;
    for (int k = 0; k < 800; k++) begin
      if (!if_pend || e_if_gnt) begin
        if_pend = ($urandom_range(0, 3) != 0);
        if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if_flush = ($urandom_range(0, 9) == 0);
      if (if_flush) if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      if (!d_pend || e_d_gnt) begin
        d_pend  = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom);
        d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom;
      end
      if_req = if_pend;
      d_req  = d_pend;
      rst    = ($urandom_range(0, 149) == 0);
      cycle_begin();
      n_vec++; if ({if_gnt_a, d_gnt_a} !== {e_if_gnt, e_d_gnt}) begin n_err++; $display("FAIL rnd_gnt_a c%0d: got %b want %b", k, {if_gnt_a, d_gnt_a}, {e_if_gnt, e_d_gnt}); end
      n_vec++; if ({if_gnt_b, d_gnt_b} !== {e_if_gnt, e_d_gnt}) begin n_err++; $display("FAIL rnd_gnt_b c%0d: got %b want %b", k, {if_gnt_b, d_gnt_b}, {e_if_gnt, e_d_gnt}); end
      n_vec++; if ({mem_en_a, mem_we_a, mem_be_a, mem_addr_a, mem_wdata_a} !== {e_mem_en, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata}) begin n_err++; $display("FAIL rnd_mem_a c%0d: got en=%b we=%b be=%b a=%h wd=%h want en=%b we=%b be=%b a=%h wd=%h", k, mem_en_a, mem_we_a, mem_be_a, mem_addr_a, mem_wdata_a, e_mem_en, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata); end
      n_vec++; if ({mem_en_b, mem_we_b, mem_be_b, mem_addr_b, mem_wdata_b} !== {e_mem_en, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata}) begin n_err++; $display("FAIL rnd_mem_b c%0d: got en=%b a=%h", k, mem_en_b, mem_addr_b); end
      n_vec++; if ({if_rvalid_a, d_rvalid_a} !== {e_if_rv_a, e_d_rv_a}) begin n_err++; $display("FAIL rnd_rv_a c%0d: got if/d=%b want %b", k, {if_rvalid_a, d_rvalid_a}, {e_if_rv_a, e_d_rv_a}); end
      n_vec++; if ({if_rvalid_b, d_rvalid_b} !== {e_if_rv_b, e_d_rv_b}) begin n_err++; $display("FAIL rnd_rv_b c%0d: got if/d=%b want %b", k, {if_rvalid_b, d_rvalid_b}, {e_if_rv_b, e_d_rv_b}); end
      if (e_if_rv_a) begin n_vec++; if (if_rdata_a !== e_data_a) begin n_err++; $display("FAIL rnd_if_data_a c%0d: got %h want %h", k, if_rdata_a, e_data_a); end end
      if (e_d_rv_a)  begin n_vec++; if (d_rdata_a !== e_data_a) begin n_err++; $display("FAIL rnd_d_data_a c%0d: got %h want %h", k, d_rdata_a, e_data_a); end end
      if (e_if_rv_b) begin n_vec++; if (if_rdata_b !== e_data_b) begin n_err++; $display("FAIL rnd_if_data_b c%0d: got %h want %h", k, if_rdata_b, e_data_b); end end
      if (e_d_rv_b)  begin n_vec++; if (d_rdata_b !== e_data_b) begin n_err++; $display("FAIL rnd_d_data_b c%0d: got %h want %h", k, d_rdata_b, e_data_b); end end
      cycle_end();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    cyc = 0;
    starve = 0;
    for (int i = 0; i < 8; i++) begin
      slot_a[i] = '{1'b0, 1'b0, 32'h0};
      slot_b[i] = '{1'b0, 1'b0, 32'h0};
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-port main memory between the instruction fetch stage and the data (load/store) stage. It issues at most one memory command per cycle and tracks in-flight reads in a tag pipeline. Each read response is returned to the requester that issued it. The fetch path gets a starvation guard and a flush that discards stale fetch responses after a branch or jump redirect.

Parameters:
ADDR_W, 32, address width for both requesters and the memory port
DATA_W, 32, data width
RD_LATENCY, 1, memory read latency in cycles; legal range 1..4
STARVE_LIMIT, 4, number of consecutive lost conflicts after which fetch wins; legal range 1..15

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  asynchronous, active-high reset
i_if_req  in  1  fetch read request
i_if_addr  in  ADDR_W  fetch address
i_if_flush  in  1  redirect; kills fetch reads in flight
o_if_gnt  out  1  fetch command issued this cycle
o_if_rvalid  out  1  fetch read data valid
o_if_rdata  out  DATA_W  fetch read data (instruction)
i_d_req  in  1  data request
i_d_we  in  1  1 = store, 0 = load
i_d_be  in  DATA_W/8  store byte enables
i_d_addr  in  ADDR_W  data address
i_d_wdata  in  DATA_W  store data
o_d_gnt  out  1  data command issued this cycle
o_d_rvalid  out  1  load data valid
o_d_rdata  out  DATA_W  load data
o_mem_en  out  1  memory command valid
o_mem_we  out  1  memory write
o_mem_be  out  DATA_W/8  memory byte enables
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid RD_LATENCY cycles after a read command

Behaviour:
- Reset (async assert, sync-safe release): tag pipeline cleared, starvation counter = 0.
  - While i_rst = 1, the following are forced to 0: all gnt, rvalid and o_mem_en/we/be outputs.
- Reset mid-operation discards all in-flight reads; no rvalid is asserted for them after release.
- Request handshake:
  - A requester holds req, addr, and (for data) we/be/wdata stable until it sees gnt high.
  - gnt is combinational, in the same cycle the command is issued.
  - A request is consumed on the cycle gnt = 1.
- Arbitration, one grant per cycle:
  - Only one requester active: it is granted.
  - Both active: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - i_if_flush = 1 suppresses o_if_gnt that cycle; if data is requesting, data is granted.
- Starvation counter:
  - Increments when both requesters are active and data is granted.
  - Clears to 0 when fetch is granted or i_if_req = 0.
  - Saturates at STARVE_LIMIT.
- Memory command mux:
  - o_mem_en = o_if_gnt | o_d_gnt.
  - On a fetch grant: addr = i_if_addr, we = 0, be = all ones.
  - On a data grant: addr/we/be/wdata come from the data port.
  - Idle cycle: en = 0 and all other memory outputs = 0.
- Tag pipeline: RD_LATENCY stages of {valid, owner}.
  - Stage 0 loads {1, IF} on a fetch grant, {1, D} on a data load grant, and {0, x} otherwise. Stores are never tagged.
  - Each stage shifts once per cycle.
- Response:
  - o_if_rvalid = last stage valid & owner IF; o_d_rvalid = last stage valid & owner D.
  - o_if_rdata and o_d_rdata = i_mem_rdata; contents are meaningful only when the matching rvalid is high.
- Flush:
  - On the clock edge where i_if_flush = 1, every pipeline stage with owner IF is invalidated.
  - Data-owned stages are untouched.
  - o_if_rvalid is also forced to 0 combinationally during the flush cycle itself.
- Ordering: responses return strictly in grant order. At most one response is valid per cycle.
- Throughput: with continuous requests, one command per cycle and one response per cycle.

Test Plan:
- Fetch only, RD_LATENCY = 1: i_if_req held for 3 cycles with addresses 0, 4, 8 -> o_if_gnt high 3 cycles; o_if_rvalid high on cycles 1–3 carrying mem[0], mem[4], mem[8].
- Simultaneous fetch and data load at address 0x100 -> o_d_gnt = 1 and o_if_gnt = 0 that cycle; fetch is granted the next cycle; responses are D then IF.
- Data requests continuously with fetch pending, STARVE_LIMIT = 4 -> data is granted 4 cycles, fetch is granted on cycle 5, and the counter returns to 0.
- Flush: fetch granted at address 8, then i_if_flush = 1 on the next edge with RD_LATENCY = 2 -> no o_if_rvalid for address 8. A data load granted in the same window still returns.
- Store of 0xDEADBEEF with be = 4'b0011 at address 0x20 -> o_mem_we = 1 and o_mem_be = 0011 for exactly one cycle; no o_d_rvalid follows.
- i_rst asserted while 2 reads are in flight with RD_LATENCY = 2 -> all outputs go to 0 immediately, and no rvalid appears after release.
